// File: rtl/timer_bank_pkg.sv
// Shared constants for the timer bank: register offsets within a channel block
// and TCON bit positions.
package timer_bank_pkg;

  localparam logic [3:0]  OFF_TH    = 4'h0;
  localparam logic [3:0]  OFF_TL    = 4'h4;
  localparam logic [3:0]  OFF_TCON  = 4'h8;
  localparam logic [3:0]  OFF_PSC   = 4'hC;
  localparam int unsigned CH_STRIDE = 16;

  localparam int TCON_EN      = 0;
  localparam int TCON_IE      = 1;
  localparam int TCON_PEND    = 2;
  localparam int TCON_ONESHOT = 3;

endpackage

// File: rtl/timer_bank_if.sv
// Processor-bus slave port of the timer bank. A write is accepted on every
// rising clk edge with wr=1; rdata is combinational and valid while rd=1.
interface timer_bank_if;

  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);

endinterface

// File: rtl/timer_channel.sv
// One timer channel: reload/count/control/prescale registers, prescaler and
// overflow handling. Bus writes arrive as pre-decoded strobes.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_th,
  input  logic             we_tl,
  input  logic             we_tcon,
  input  logic             we_psc,
  input  logic             clr_pend,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] th_o,
  output logic [CNT_W-1:0] tl_o,
  output logic [3:0]       tcon_o,
  output logic [PSC_W-1:0] psc_o,
  output logic             pend_o
);

  logic [CNT_W-1:0] th_q, th_d, tl_q, tl_d;
  logic [PSC_W-1:0] psc_q, psc_d, pc_q, pc_d;
  logic             en_q, en_d, ie_q, ie_d, pend_q, pend_d, os_q, os_d;
  logic             tick, ovf;

  always_comb begin
    tick = en_q && (pc_q == psc_q);
    // A TL write in the same cycle suppresses both increment and overflow.
    ovf  = tick && !we_tl && (&tl_q);

    if (we_psc || !en_q || tick) pc_d = '0;
    else                         pc_d = pc_q + 1'b1;

    th_d  = we_th  ? wdata[CNT_W-1:0] : th_q;
    psc_d = we_psc ? wdata[PSC_W-1:0] : psc_q;

    if (we_tl)     tl_d = wdata[CNT_W-1:0];
    else if (ovf)  tl_d = th_q;
    else if (tick) tl_d = tl_q + 1'b1;
    else           tl_d = tl_q;

    ie_d = we_tcon ? wdata[TCON_IE]      : ie_q;
    os_d = we_tcon ? wdata[TCON_ONESHOT] : os_q;

    if (we_tcon)          en_d = wdata[TCON_EN];
    else if (ovf && os_q) en_d = 1'b0;
    else                  en_d = en_q;

    // Hardware set is applied last so it beats software clears in the same cycle.
    pend_d = pend_q;
    if (we_tcon)     pend_d = wdata[TCON_PEND];
    if (clr_pend)    pend_d = 1'b0;
    if (ovf && ie_q) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q   <= '0;
      tl_q   <= '0;
      psc_q  <= '0;
      pc_q   <= '0;
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
      os_q   <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      psc_q  <= psc_d;
      pc_q   <= pc_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
      os_q   <= os_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign psc_o  = psc_q;
  assign tcon_o = {os_q, pend_q, ie_q, en_q};
  assign pend_o = pend_q;

endmodule

// File: rtl/timer_bank.sv
// N independent timer channels behind one MMIO slave port, with a W1C global
// IRQ status register and a kernel-mode-masked interrupt line.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          N_CH      = 4,
  parameter int          CNT_W     = 32,
  parameter int          PSC_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            reset,
  timer_bank_if.slave     bus,
  input  logic            PC31,
  output logic            irqout,
  output logic [N_CH-1:0] irq_vec
);

  localparam logic [31:0] STAT_OFF = 32'(CH_STRIDE * N_CH);

  logic [31:0]      rel;
  logic [N_CH-1:0]  ch_sel;
  logic             stat_sel;
  logic [CNT_W-1:0] th_r   [N_CH];
  logic [CNT_W-1:0] tl_r   [N_CH];
  logic [3:0]       tcon_r [N_CH];
  logic [PSC_W-1:0] psc_r  [N_CH];

  assign rel      = bus.addr - BASE_ADDR;
  assign stat_sel = (rel == STAT_OFF);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    // Offsets are matched exactly, so unaligned addresses decode as unmapped.
    assign ch_sel[k] = (rel[31:4] == 28'(k));

    timer_channel #(.CNT_W(CNT_W), .PSC_W(PSC_W)) u_ch (
      .clk      (clk),
      .rst_n    (reset),
      .we_th    (bus.wr && ch_sel[k] && (rel[3:0] == OFF_TH)),
      .we_tl    (bus.wr && ch_sel[k] && (rel[3:0] == OFF_TL)),
      .we_tcon  (bus.wr && ch_sel[k] && (rel[3:0] == OFF_TCON)),
      .we_psc   (bus.wr && ch_sel[k] && (rel[3:0] == OFF_PSC)),
      .clr_pend (bus.wr && stat_sel && bus.wdata[k]),
      .wdata    (bus.wdata),
      .th_o     (th_r[k]),
      .tl_o     (tl_r[k]),
      .tcon_o   (tcon_r[k]),
      .psc_o    (psc_r[k]),
      .pend_o   (irq_vec[k])
    );
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (stat_sel) bus.rdata = 32'(irq_vec);
      for (int k = 0; k < N_CH; k++) begin
        if (ch_sel[k]) begin
          case (rel[3:0])
            OFF_TH:   bus.rdata = 32'(th_r[k]);
            OFF_TL:   bus.rdata = 32'(tl_r[k]);
            OFF_TCON: bus.rdata = 32'(tcon_r[k]);
            OFF_PSC:  bus.rdata = 32'(psc_r[k]);
            default:  bus.rdata = '0;
          endcase
        end
      end
    end
  end

  assign irqout = ~PC31 & (|irq_vec);

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus randomized bus
// traffic compared against a cycle-level behavioural model of the channels.
module tb_timer_bank;

  localparam int              N_CH  = 4;
  localparam int              CNT_W = 32;
  localparam int              PSC_W = 16;
  localparam logic [31:0]     BASE  = 32'h4000_0100;
  localparam logic [31:0]     STAT  = BASE + 32'(16 * N_CH);
  localparam longint unsigned MAXV  = (64'd1 << CNT_W) - 64'd1;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic            PC31  = 1'b0;
  logic            irqout;
  logic [N_CH-1:0] irq_vec;

  timer_bank_if bus();

  timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .PSC_W(PSC_W), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .PC31    (PC31),
    .irqout  (irqout),
    .irq_vec (irq_vec)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  longint unsigned m_th [N_CH];
  longint unsigned m_tl [N_CH];
  int unsigned     m_psc[N_CH];
  int unsigned     m_pc [N_CH];
  bit              m_en [N_CH];
  bit              m_ie [N_CH];
  bit              m_pend[N_CH];
  bit              m_os [N_CH];

  logic [31:0]     m_rel;
  bit              w_th, w_tl, w_tc, w_psc, w_clr, tick, wrap;
  longint unsigned n_tl, n_th;
  int unsigned     n_pc, n_psc;
  bit              n_en, n_ie, n_pend, n_os;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_CH; k++) begin
        m_th[k] = 0; m_tl[k] = 0; m_psc[k] = 0; m_pc[k] = 0;
        m_en[k] = 0; m_ie[k] = 0; m_pend[k] = 0; m_os[k] = 0;
      end
    end else begin
      m_rel = bus.addr - BASE;
      for (int k = 0; k < N_CH; k++) begin
        w_th  = bus.wr && (m_rel == 32'(16 * k));
        w_tl  = bus.wr && (m_rel == 32'(16 * k + 4));
        w_tc  = bus.wr && (m_rel == 32'(16 * k + 8));
        w_psc = bus.wr && (m_rel == 32'(16 * k + 12));
        w_clr = bus.wr && (m_rel == 32'(16 * N_CH)) && bus.wdata[k];
        tick  = m_en[k] && (m_pc[k] == m_psc[k]);
        wrap  = tick && !w_tl && (m_tl[k] == MAXV);

        n_pc  = (w_psc || !m_en[k] || tick) ? 0 : m_pc[k] + 1;
        n_th  = w_th  ? (64'(bus.wdata) & MAXV) : m_th[k];
        n_psc = w_psc ? int'(bus.wdata[PSC_W-1:0]) : m_psc[k];
        if (w_tl)      n_tl = 64'(bus.wdata) & MAXV;
        else if (wrap) n_tl = m_th[k];
        else if (tick) n_tl = m_tl[k] + 1;
        else           n_tl = m_tl[k];
        n_ie = w_tc ? bus.wdata[1] : m_ie[k];
        n_os = w_tc ? bus.wdata[3] : m_os[k];
        n_en = w_tc ? bus.wdata[0] : ((wrap && m_os[k]) ? 1'b0 : m_en[k]);
        n_pend = m_pend[k];
        if (w_tc)             n_pend = bus.wdata[2];
        if (w_clr)            n_pend = 1'b0;
        if (wrap && m_ie[k])  n_pend = 1'b1;

        m_th[k] = n_th; m_tl[k] = n_tl; m_psc[k] = n_psc; m_pc[k] = n_pc;
        m_en[k] = n_en; m_ie[k] = n_ie; m_pend[k] = n_pend; m_os[k] = n_os;
      end
    end
  end

  function automatic logic [N_CH-1:0] model_pend();
    logic [N_CH-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k] = m_pend[k];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    logic [31:0] v;
    r = a - BASE;
    v = '0;
    if (r == 32'(16 * N_CH)) v = 32'(model_pend());
    for (int k = 0; k < N_CH; k++) begin
      if (r == 32'(16 * k))      v = 32'(m_th[k]);
      if (r == 32'(16 * k + 4))  v = 32'(m_tl[k]);
      if (r == 32'(16 * k + 8))  v = {28'b0, m_os[k], m_pend[k], m_ie[k], m_en[k]};
      if (r == 32'(16 * k + 12)) v = m_psc[k];
    end
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    bus.rd = 1'b1; bus.addr = a;
    #1;
    d = bus.rdata;
    bus.rd = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 4 * N_CH + 1; k++) begin
      @(negedge clk);
      do_read(BASE + 32'(4 * k), d);
      checks++;
      if (d !== 32'h0) begin
        failures++; $display("FAIL reset_reg[%0d]: got %h expected %h", k, d, 32'h0);
      end
    end
    checks++;
    if (irqout !== 1'b0 || irq_vec !== '0) begin
      failures++; $display("FAIL reset_irq: got irqout=%b vec=%b expected 0/0", irqout, irq_vec);
    end
    // Run ch0 from TL=5 with PEND raised by software, then reset mid-count.
    bus_write(BASE + 4, 32'd5);
    bus_write(BASE + 8, 32'h5);
    repeat (3) @(posedge clk);
    #2;
    do_read(BASE + 4, d);
    checks++;
    if (d !== 32'd8) begin
      failures++; $display("FAIL midcount_tl: got %h expected %h", d, 32'd8);
    end
    checks++;
    if (irqout !== 1'b1) begin
      failures++; $display("FAIL midcount_irq: got %b expected 1", irqout);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (irqout !== 1'b0 || irq_vec !== '0) begin
      failures++; $display("FAIL async_reset_irq: got irqout=%b vec=%b expected 0/0", irqout, irq_vec);
    end
    do_read(BASE + 4, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL async_reset_tl: got %h expected 0", d);
    end
    do_read(BASE + 8, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL async_reset_tcon: got %h expected 0", d);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    bus_write(BASE + 0,  32'hFFFF_FFF0);
    bus_write(BASE + 4,  32'hFFFF_FFFC);
    bus_write(BASE + 12, 32'h0);
    bus_write(BASE + 8,  32'h3);
    repeat (3) @(posedge clk);
    #1;
    do_read(BASE + 4, d);
    checks++;
    if (d !== 32'hFFFF_FFFF || irq_vec[0] !== 1'b0) begin
      failures++; $display("FAIL reload_pre: got tl=%h pend=%b expected ffffffff/0", d, irq_vec[0]);
    end
    @(posedge clk);
    #1;
    do_read(BASE + 4, d);
    checks++;
    if (d !== 32'hFFFF_FFF0 || irq_vec[0] !== 1'b1) begin
      failures++; $display("FAIL reload_wrap: got tl=%h pend=%b expected fffffff0/1", d, irq_vec[0]);
    end
    PC31 = 1'b0;
    #1;
    checks++;
    if (irqout !== 1'b1) begin
      failures++; $display("FAIL irq_user: got %b expected 1", irqout);
    end
    PC31 = 1'b1;
    #1;
    checks++;
    if (irqout !== 1'b0) begin
      failures++; $display("FAIL irq_kernel_mask: got %b expected 0", irqout);
    end
    PC31 = 1'b0;
    bus_write(BASE + 8, 32'h0);
    checks++;
    if (irq_vec !== '0) begin
      failures++; $display("FAIL reload_clear: got %b expected 0", irq_vec);
    end
  endtask

  task automatic test_oneshot_psc();
    logic [31:0] d;
    bus_write(BASE + 16, 32'h0000_1234);
    bus_write(BASE + 20, 32'hFFFF_FFFE);
    bus_write(BASE + 28, 32'd3);
    bus_write(BASE + 24, 32'hB);
    repeat (7) @(posedge clk);
    #1;
    do_read(BASE + 20, d);
    checks++;
    if (d !== 32'hFFFF_FFFF || irq_vec[1] !== 1'b0) begin
      failures++; $display("FAIL oneshot_cycle7: got tl=%h pend=%b expected ffffffff/0", d, irq_vec[1]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (irq_vec[1] !== 1'b1) begin
      failures++; $display("FAIL oneshot_cycle8_pend: got %b expected 1", irq_vec[1]);
    end
    do_read(BASE + 24, d);
    checks++;
    if (d[2:0] !== 3'b110 || d !== model_read(BASE + 24)) begin
      failures++; $display("FAIL oneshot_tcon: got %h expected %h", d, model_read(BASE + 24));
    end
    do_read(BASE + 20, d);
    checks++;
    if (d !== 32'h0000_1234) begin
      failures++; $display("FAIL oneshot_tl_reload: got %h expected 00001234", d);
    end
    repeat (10) @(posedge clk);
    #1;
    do_read(BASE + 20, d);
    checks++;
    if (d !== 32'h0000_1234) begin
      failures++; $display("FAIL oneshot_stopped: got %h expected 00001234", d);
    end
    bus_write(BASE + 24, 32'h0);
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    bus_write(BASE + 32, 32'h0);
    bus_write(BASE + 36, 32'hFFFF_FFFD);
    bus_write(BASE + 40, 32'h3);
    repeat (2) @(posedge clk);
    bus_write(STAT, 32'h4);
    checks++;
    if (irq_vec[2] !== 1'b1) begin
      failures++; $display("FAIL w1c_race_hw_wins: got %b expected 1", irq_vec[2]);
    end
    do_read(BASE + 36, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL w1c_race_tl: got %h expected 0", d);
    end
    bus_write(STAT, 32'h4);
    checks++;
    if (irq_vec[2] !== 1'b0 || irqout !== 1'b0) begin
      failures++; $display("FAIL w1c_clear: got pend=%b irqout=%b expected 0/0", irq_vec[2], irqout);
    end
    bus_write(BASE + 40, 32'h0);
  endtask

  task automatic test_tl_write_tick();
    logic [31:0] d;
    bus_write(BASE + 60, 32'h0);
    bus_write(BASE + 52, 32'h100);
    bus_write(BASE + 56, 32'h1);
    repeat (5) @(posedge clk);
    bus_write(BASE + 52, 32'h10);
    do_read(BASE + 52, d);
    checks++;
    if (d !== 32'h10) begin
      failures++; $display("FAIL tl_write_wins: got %h expected 00000010", d);
    end
    @(posedge clk);
    #1;
    do_read(BASE + 52, d);
    checks++;
    if (d !== 32'h11) begin
      failures++; $display("FAIL tl_after_write: got %h expected 00000011", d);
    end
    bus_write(BASE + 56, 32'h0);
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic [31:0] bad [4];
    bad[0] = STAT + 4; bad[1] = BASE - 4; bad[2] = BASE + 32'h200; bad[3] = BASE + 2;
    @(negedge clk);
    do_read(STAT + 4, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL unmapped_read: got %h expected 0", d);
    end
    bus.rd = 1'b0; bus.addr = BASE + 4;
    #1;
    checks++;
    if (bus.rdata !== 32'h0) begin
      failures++; $display("FAIL rd_low_read: got %h expected 0", bus.rdata);
    end
    for (int i = 0; i < 4; i++) bus_write(bad[i], $urandom());
    for (int k = 0; k < 4 * N_CH + 1; k++) begin
      @(negedge clk);
      do_read(BASE + 32'(4 * k), d);
      checks++;
      if (d !== model_read(BASE + 32'(4 * k))) begin
        failures++;
        $display("FAIL unmapped_write_reg[%0d]: got %h expected %h", k, d, model_read(BASE + 32'(4 * k)));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, a;
    int          op, ch, rg;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      PC31 = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (irq_vec !== model_pend()) begin
        failures++; $display("FAIL rand_irq_vec[%0d]: got %b expected %b", i, irq_vec, model_pend());
      end
      checks++;
      if (irqout !== (~PC31 & (|model_pend()))) begin
        failures++; $display("FAIL rand_irqout[%0d]: got %b expected %b", i, irqout, ~PC31 & (|model_pend()));
      end
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, N_CH);
      rg = $urandom_range(0, 3);
      a  = (ch == N_CH) ? STAT : BASE + 32'(16 * ch + 4 * rg);
      if (op < 6) begin
        do_read(a, d);
        checks++;
        if (d !== model_read(a)) begin
          failures++; $display("FAIL rand_read[%0d] @%h: got %h expected %h", i, a, d, model_read(a));
        end
      end else begin
        if (ch == N_CH)   d = $urandom_range(0, 15);
        else if (rg == 0) d = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
        else if (rg == 1) d = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        else if (rg == 2) d = ($urandom() & 32'hFFFF_FFF0) | $urandom_range(0, 15);
        else              d = ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 3);
        bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
      end
    end
  endtask

  initial begin
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_auto_reload();
    test_oneshot_psc();
    test_w1c_race();
    test_tl_write_tick();
    test_decode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
